// File: rtl/itransform_pkg.sv
// Shared constants and fixed-point multiply helpers for the VP8 inverse 4x4 transform.
package itransform_pkg;

    // Fixed-point multipliers: MUL1 ~ x*sqrt(2)*cos(pi/8), MUL2 ~ x*sqrt(2)*sin(pi/8)
    localparam int K_MUL1    = 20091;
    localparam int K_MUL2    = 35468;
    localparam int MUL_SHIFT = 16;

    // Final rounding: +4 folded into the DC term of pass 2, then >>> 3
    localparam int DC_RND    = 4;
    localparam int OUT_SHIFT = 3;

    // Pass 1 result width and pass 2 result width
    localparam int T_WIDTH   = 16;
    localparam int V_WIDTH   = 18;

    // ((x * K_MUL1) >>> 16) + x, floor shift; 48-bit product never overflows for 32-bit x
    function automatic logic signed [31:0] mul1(input logic signed [31:0] x);
        logic signed [47:0] p;
        p = 48'(x) * 48'(K_MUL1);
        return 32'(p >>> MUL_SHIFT) + x;
    endfunction

    // (x * K_MUL2) >>> 16, floor shift
    function automatic logic signed [31:0] mul2(input logic signed [31:0] x);
        logic signed [47:0] p;
        p = 48'(x) * 48'(K_MUL2);
        return 32'(p >>> MUL_SHIFT);
    endfunction

endpackage

// File: rtl/itransform_1d.sv
// Combinational 4-point inverse butterfly shared by the vertical and horizontal passes.
module itransform_1d
    import itransform_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 12,
    parameter int unsigned OUT_WIDTH = 16
) (
    input  logic signed [IN_WIDTH-1:0]  x0,
    input  logic signed [IN_WIDTH-1:0]  x1,
    input  logic signed [IN_WIDTH-1:0]  x2,
    input  logic signed [IN_WIDTH-1:0]  x3,
    output logic signed [OUT_WIDTH-1:0] y0,
    output logic signed [OUT_WIDTH-1:0] y1,
    output logic signed [OUT_WIDTH-1:0] y2,
    output logic signed [OUT_WIDTH-1:0] y3
);

    logic signed [31:0] a;
    logic signed [31:0] b;
    logic signed [31:0] cc;
    logic signed [31:0] d;

    // Even/odd butterfly; results are truncated to the declared output width
    always_comb begin
        a  = 32'(x0) + 32'(x2);
        b  = 32'(x0) - 32'(x2);
        cc = mul2(32'(x1)) - mul1(32'(x3));
        d  = mul1(32'(x1)) + mul2(32'(x3));
        y0 = OUT_WIDTH'(a + d);
        y1 = OUT_WIDTH'(b + cc);
        y2 = OUT_WIDTH'(b - cc);
        y3 = OUT_WIDTH'(a - d);
    end

endmodule

// File: rtl/itransform.sv
// VP8 inverse 4x4 transform plus reconstruction (residual + prediction, clip to pixel range).
// Two-stage valid/ready pipeline: S1 holds pass-1 results, S2 holds the clipped block.
// Optional build macro ITRANSFORM_SAT_EN adds the registered 'sat' output flag.
// The prediction input is named ref_pix because 'ref' is a reserved word.
module itransform
    import itransform_pkg::*;
#(
    parameter int unsigned I_WIDTH = 12,
    parameter int unsigned P_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [I_WIDTH*16-1:0] coef,
    input  logic [P_WIDTH*16-1:0] ref_pix,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [P_WIDTH*16-1:0] out
`ifdef ITRANSFORM_SAT_EN
    ,
    output logic                  sat
`endif
);

    localparam int PIX_MAX = (1 << P_WIDTH) - 1;

    logic                      adv;

    logic signed [T_WIDTH-1:0] t_d [16];
    logic signed [T_WIDTH-1:0] t_q [16];
    logic [P_WIDTH*16-1:0]     ref_q;
    logic                      v1_q;

    logic signed [T_WIDTH:0]   j0 [4];
    logic signed [T_WIDTH:0]   j1 [4];
    logic signed [T_WIDTH:0]   j2 [4];
    logic signed [T_WIDTH:0]   j3 [4];
    logic signed [V_WIDTH-1:0] v_d [16];
    logic signed [V_WIDTH:0]   pre_clip [16];
    logic [15:0]               lo;
    logic [15:0]               hi;

    logic [P_WIDTH*16-1:0]     out_d;
    logic [P_WIDTH*16-1:0]     out_q;
    logic                      v2_q;

    // Whole pipeline moves together whenever the output slot is free or being drained
    assign adv       = !v2_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = v2_q;
    assign out       = out_q;

    // Pass 1: one vertical butterfly per column, t[4c+k] holds row k of column c
    for (genvar c = 0; c < 4; c++) begin : g_pass1
        itransform_1d #(
            .IN_WIDTH  (I_WIDTH),
            .OUT_WIDTH (T_WIDTH)
        ) u_col (
            .x0 (coef[I_WIDTH*c +: I_WIDTH]),
            .x1 (coef[I_WIDTH*(4+c) +: I_WIDTH]),
            .x2 (coef[I_WIDTH*(8+c) +: I_WIDTH]),
            .x3 (coef[I_WIDTH*(12+c) +: I_WIDTH]),
            .y0 (t_d[4*c+0]),
            .y1 (t_d[4*c+1]),
            .y2 (t_d[4*c+2]),
            .y3 (t_d[4*c+3])
        );
    end

    // S1: capture pass-1 results, prediction and valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q  <= 1'b0;
            ref_q <= '0;
            t_q   <= '{default: '0};
        end else if (adv) begin
            v1_q  <= in_valid;
            ref_q <= ref_pix;
            t_q   <= t_d;
        end
    end

    // Pass 2 operands per row; rounding constant folded into the DC term
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            j0[r] = (T_WIDTH+1)'(t_q[r]) + (T_WIDTH+1)'(DC_RND);
            j1[r] = (T_WIDTH+1)'(t_q[4+r]);
            j2[r] = (T_WIDTH+1)'(t_q[8+r]);
            j3[r] = (T_WIDTH+1)'(t_q[12+r]);
        end
    end

    // Pass 2: one horizontal butterfly per row, v[4r+col]
    for (genvar r = 0; r < 4; r++) begin : g_pass2
        itransform_1d #(
            .IN_WIDTH  (T_WIDTH + 1),
            .OUT_WIDTH (V_WIDTH)
        ) u_row (
            .x0 (j0[r]),
            .x1 (j1[r]),
            .x2 (j2[r]),
            .x3 (j3[r]),
            .y0 (v_d[4*r+0]),
            .y1 (v_d[4*r+1]),
            .y2 (v_d[4*r+2]),
            .y3 (v_d[4*r+3])
        );
    end

    // Reconstruct: prediction + scaled residual, clipped to the pixel range
    always_comb begin
        out_d = '0;
        lo    = '0;
        hi    = '0;
        for (int k = 0; k < 16; k++) begin
            pre_clip[k] = (V_WIDTH+1)'(v_d[k] >>> OUT_SHIFT)
                        + (V_WIDTH+1)'($signed({1'b0, ref_q[P_WIDTH*k +: P_WIDTH]}));
            lo[k] = pre_clip[k][V_WIDTH];
            hi[k] = !pre_clip[k][V_WIDTH] && (pre_clip[k] > (V_WIDTH+1)'(PIX_MAX));
            if (lo[k]) begin
                out_d[P_WIDTH*k +: P_WIDTH] = '0;
            end else if (hi[k]) begin
                out_d[P_WIDTH*k +: P_WIDTH] = '1;
            end else begin
                out_d[P_WIDTH*k +: P_WIDTH] = pre_clip[k][P_WIDTH-1:0];
            end
        end
    end

    // S2: output block and its valid; holds while the sink stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q  <= 1'b0;
            out_q <= '0;
        end else if (adv) begin
            v2_q  <= v1_q;
            out_q <= out_d;
        end
    end

`ifdef ITRANSFORM_SAT_EN
    logic sat_q;

    // Saturation flag travels with the block; cleared for bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (adv) begin
            sat_q <= v1_q && (|(lo | hi));
        end
    end

    assign sat = sat_q;
`endif

endmodule
